// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, stall sequencer states, counter width.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DMEM = 2'd1,
    IND  = 2'd2
  } lc3b_pipe_state;

  localparam int unsigned LC3B_PERF_CNT_W = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the decode instruction reads a register that the load in EX writes.
module hazard_detect
  import lc3b_types::*;
(
  input  logic    if_id_v,
  input  logic    id_ex_v,
  input  logic    id_ex_mem_read,
  input  lc3b_reg if_id_SR1,
  input  lc3b_reg if_id_SR2,
  input  logic    if_id_sr1_needed,
  input  logic    if_id_sr2_needed,
  input  lc3b_reg id_ex_DR,
  output logic    hazard
);

  logic sr1_hit;
  logic sr2_hit;

  assign sr1_hit = if_id_sr1_needed && (id_ex_DR == if_id_SR1);
  assign sr2_hit = if_id_sr2_needed && (id_ex_DR == if_id_SR2);
  assign hazard  = id_ex_v && id_ex_mem_read && if_id_v && (sr1_hit || sr2_hit);

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the five-stage LC-3b pipeline, including LDI/STI double access.
// PIPELINE_PERF_CNT_EN builds the saturating stall counters; otherwise they read 0.
module pipeline_control
  import lc3b_types::*;
#(
  parameter int unsigned CNT_W = LC3B_PERF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_id_v,
  input  logic             id_ex_v,
  input  logic             ex_mem_v,
  input  lc3b_reg          if_id_SR1,
  input  lc3b_reg          if_id_SR2,
  input  logic             if_id_sr1_needed,
  input  logic             if_id_sr2_needed,
  input  lc3b_reg          id_ex_DR,
  input  logic             id_ex_mem_read,
  input  logic             ex_mem_mem_read,
  input  logic             ex_mem_mem_write,
  input  logic             ex_mem_indirect,
  input  logic             ex_mem_br_taken,
  input  logic             icache_resp,
  input  logic             dcache_resp,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             id_ex_bubble,
  output logic             flush,
  output logic             load_reg,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             dmem_addr_sel,
  output logic             ind_ptr_load,
  output logic [CNT_W-1:0] stall_ld_use,
  output logic [CNT_W-1:0] stall_mem
);

  lc3b_pipe_state state, next_state;
  logic dreq;
  logic hazard;
  logic branch;
  logic frozen;

  hazard_detect u_hazard_detect (
    .if_id_v          (if_id_v),
    .id_ex_v          (id_ex_v),
    .id_ex_mem_read   (id_ex_mem_read),
    .if_id_SR1        (if_id_SR1),
    .if_id_SR2        (if_id_SR2),
    .if_id_sr1_needed (if_id_sr1_needed),
    .if_id_sr2_needed (if_id_sr2_needed),
    .id_ex_DR         (id_ex_DR),
    .hazard           (hazard)
  );

  assign dreq   = ex_mem_v && (ex_mem_mem_read || ex_mem_mem_write);
  assign branch = ex_mem_v && ex_mem_br_taken;

  // The indirect pointer fetch completes in DMEM but must not release the pipeline.
  always_comb begin
    frozen = 1'b0;
    unique case (state)
      RUN:     frozen = dreq;
      DMEM:    frozen = !dcache_resp || ex_mem_indirect;
      IND:     frozen = !dcache_resp;
      default: frozen = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      RUN:     if (dreq) next_state = DMEM;
      DMEM:    if (dcache_resp) next_state = ex_mem_indirect ? IND : RUN;
      IND:     if (dcache_resp) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    load_pc       = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    id_ex_bubble  = 1'b0;
    flush         = 1'b0;
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    dmem_addr_sel = 1'b0;
    ind_ptr_load  = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (dreq) begin
            dmem_read  = ex_mem_mem_read || ex_mem_indirect;
            dmem_write = ex_mem_mem_write && !ex_mem_indirect;
          end
        end
        DMEM: begin
          dmem_read    = ex_mem_mem_read || ex_mem_indirect;
          dmem_write   = ex_mem_mem_write && !ex_mem_indirect;
          ind_ptr_load = dcache_resp && ex_mem_indirect;
        end
        IND: begin
          dmem_addr_sel = 1'b1;
          dmem_read     = ex_mem_mem_read;
          dmem_write    = ex_mem_mem_write;
        end
        default: ;
      endcase

      if (!frozen) begin
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        if (branch) begin
          flush      = 1'b1;
          load_pc    = 1'b1;
          load_if_id = 1'b1;
        end else if (hazard || !icache_resp) begin
          id_ex_bubble = 1'b1;
        end else begin
          load_pc    = 1'b1;
          load_if_id = 1'b1;
        end
      end
    end
  end

  assign load_reg = load_id_ex;

`ifdef PIPELINE_PERF_CNT_EN
  logic [CNT_W-1:0] ld_use_cnt;
  logic [CNT_W-1:0] mem_cnt;
  logic             ld_use_bubble;

  assign ld_use_bubble = !frozen && !branch && hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_use_cnt <= '0;
      mem_cnt    <= '0;
    end else begin
      if (ld_use_bubble && !(&ld_use_cnt)) ld_use_cnt <= ld_use_cnt + CNT_W'(1);
      if (frozen && !(&mem_cnt))           mem_cnt    <= mem_cnt + CNT_W'(1);
    end
  end

  assign stall_ld_use = reset ? '0 : ld_use_cnt;
  assign stall_mem    = reset ? '0 : mem_cnt;
`else
  assign stall_ld_use = '0;
  assign stall_mem    = '0;
`endif

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush sequencer for the five-stage LC-3b pipeline. It generates the per-stage register load enables and the load-use bubble, and sequences multi-cycle D-cache accesses, including the two-access LDI/STI indirect. It drives `load_reg` for the ALU operand forwarding logic, so forwarding selects change only when ID/EX advances. It sits beside the stage registers and consumes only decoded stage fields and cache handshakes.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `if_id_v`, `id_ex_v`, `ex_mem_v` in 1: stage valid bits.
- `if_id_SR1`, `if_id_SR2` in `lc3b_reg`: source registers of the instruction in decode.
- `if_id_sr1_needed`, `if_id_sr2_needed` in 1: the decode instruction reads that source.
- `id_ex_DR` in `lc3b_reg`: destination register in EX.
- `id_ex_mem_read` in 1: the EX instruction is LDR/LDB/LDI.
- `ex_mem_mem_read`, `ex_mem_mem_write`, `ex_mem_indirect` in 1: access type of the MEM instruction.
- `ex_mem_br_taken` in 1: resolved taken branch/JMP/JSR/TRAP in MEM.
- `icache_resp`, `dcache_resp` in 1: cache completion strobes.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb` out 1: stage register enables.
- `id_ex_bubble` out 1: load ID/EX with `v=0`.
- `flush` out 1: clear `v` of IF/ID, ID/EX and EX/MEM on the next edge.
- `load_reg` out 1: equals `load_id_ex`.
- `dmem_read`, `dmem_write` out 1: D-cache request.
- `dmem_addr_sel` out 1: 0 = EX/MEM address, 1 = latched indirect pointer.
- `ind_ptr_load` out 1: latch D-cache read data as the indirect pointer.
- `stall_ld_use`, `stall_mem` out `CNT_W`: performance counters.

## Operation
- States: RUN, DMEM (first or only access pending), IND (second indirect access pending).
- Request qualifier: `dreq = ex_mem_v & (ex_mem_mem_read | ex_mem_mem_write)`.
- RUN, dreq=0: no D-cache access this cycle.
- RUN, dreq=1: go to DMEM and assert the request the same cycle.
  - `dmem_read` = read, or indirect (the first indirect access is always a read).
  - `dmem_write` = write & ~indirect.
- DMEM, `dcache_resp`=1:
  - Non-indirect: go to RUN; the pipeline advances this cycle.
  - Indirect: assert `ind_ptr_load` and go to IND; the pipeline stays frozen.
- DMEM, `dcache_resp`=0: stay in DMEM.
- IND: `dmem_addr_sel`=1.
  - `dmem_read` = ex_mem_mem_read; `dmem_write` = ex_mem_mem_write.
  - On `dcache_resp`, go to RUN and advance.
- Freeze (all `load_*`=0) whenever:
  - state is DMEM or IND without the completing response, or
  - state is RUN with dreq=1.
- Pipeline actions, applied when not frozen, in priority order:
  - Branch: `ex_mem_br_taken` & `ex_mem_v` → `flush`=1, `load_pc`=1, all loads 1.
  - Load-use hazard:
    - Condition: `id_ex_v & id_ex_mem_read & if_id_v`, and (sr1 needed and `id_ex_DR==if_id_SR1`) or (sr2 needed and `id_ex_DR==if_id_SR2`).
    - Action: `load_pc`=0, `load_if_id`=0, `id_ex_bubble`=1, `load_id_ex`/`load_ex_mem`/`load_mem_wb`=1.
  - I-cache miss (`icache_resp`=0): `load_pc`=0, `load_if_id`=0, `id_ex_bubble`=1, downstream loads 1.
  - Otherwise: all loads 1.
- Flush dominates load-use and I-miss in the same cycle.

## Timing
- Reset (synchronous, highest priority):
  - state ← RUN; counters ← 0.
  - While `reset` is high, every output is 0 and any pending cache transaction is abandoned.
- Outputs are Mealy: combinational from state and inputs. Only the state and the counters are registered.
- D-access latency: N cycles in DMEM until `dcache_resp`, then advance on the response cycle. A single-cycle hit costs exactly 1 frozen cycle (RUN→DMEM, advance in DMEM).
- Indirect latency: N1 + N2 cycles plus the response cycles. `ind_ptr_load` pulses exactly once.
- `dcache_resp` arriving in RUN is ignored.

## Configuration
- `PIPELINE_PERF_CNT_EN` defined:
  - `stall_ld_use` increments on each load-use bubble cycle.
  - `stall_mem` increments on each frozen cycle.
  - Both counters saturate at all-ones.
- Undefined: both counter outputs tied to 0 and the registers are not built.

## Structure
- `lc3b_types` holds:
  - `lc3b_reg`
  - the state enum `lc3b_pipe_state` {RUN, DMEM, IND}
  - constant `LC3B_PERF_CNT_W`
- Sub-module `hazard_detect`: the combinational load-use comparator, kept separate for reuse and unit test.
- The state machine, request logic and counters live in `pipeline_control`.

## Test plan
- LDR R1 in EX, ADD R2,R1,R3 in decode (sr1 needed) → one cycle of `load_pc`=0, `load_if_id`=0, `id_ex_bubble`=1; `stall_ld_use`=1.
- LDR in MEM, `dcache_resp` delayed 3 cycles → 3 cycles in DMEM with all loads 0 and `dmem_read`=1, advance on the resp cycle; `stall_mem`=4.
- STI in MEM, resp after 2 and then 1 cycles:
  - `ind_ptr_load` pulses once.
  - IND asserts `dmem_write`=1 with `dmem_addr_sel`=1.
  - Return to RUN afterwards.
- Taken BR in MEM coincident with a load-use hazard → `flush`=1 and `load_pc`=1; `id_ex_bubble`=0.
- `reset` asserted in DMEM mid-miss → the next cycle is RUN, all outputs 0 while reset is high, counters 0.
- `icache_resp`=0 for 2 cycles with an empty MEM stage → 2 bubbles inserted, PC held, `load_ex_mem`=1.
